// File: rtl/nn_frame_sequencer.sv
// nn_frame_sequencer: buffers one 784-pixel frame, streams it to nn gap-free and hands the class to the host.
// Optional result watchdog enabled by defining SEQ_TIMEOUT_EN.
module nn_frame_sequencer #(
   parameter int INPUTsize = 784,
   parameter int DW        = 8,
   parameter int AW        = 10,
   parameter int CLASSW    = 4,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic signed [DW-1:0] wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic signed [DW-1:0] x,
   output logic                 x_valid,
   input  logic                 nn_done,
   input  logic [CLASSW-1:0]    nn_class,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [CLASSW-1:0]    res_class,
   output logic                 res_err,
   output logic [15:0]          frame_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_RESULT} state_t;

   state_t                state, state_nxt;
   logic signed [DW-1:0]  mem [INPUTsize];
   logic signed [DW-1:0]  rdata;
   logic [AW-1:0]         rd_addr;
   logic                  rd_v;
   logic                  last_addr;
   logic                  buf_we;
   logic                  timeout;

   if ((2 ** AW) < INPUTsize || TIMEOUT < 2) begin : g_cfg_check
      $error("nn_frame_sequencer: AW too small for INPUTsize, or TIMEOUT < 2");
   end

   assign last_addr = (rd_addr == AW'(INPUTsize - 1));
   assign buf_we    = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < (AW+1)'(INPUTsize));
   assign busy      = (state != S_IDLE);

   // Buffer has no reset: contents survive Rst.
   always_ff @(posedge Clk) begin
      if (buf_we) mem[wr_addr] <= wr_data;
      rdata <= mem[rd_addr];
   end

`ifdef SEQ_TIMEOUT_EN
   logic [15:0] wdog;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                 wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 16'd1;
      else                      wdog <= '0;
   end

   assign timeout = (state == S_WAIT) && (wdog == 16'(TIMEOUT - 1));

   // nn_done on the timeout cycle wins, so the error flag is just !nn_done.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         res_err <= 1'b0;
      else if (state == S_WAIT && (nn_done || timeout))
         res_err <= !nn_done;
   end
`else
   assign timeout = 1'b0;
   assign res_err = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)              state_nxt = S_STREAM;
         S_STREAM: if (last_addr)          state_nxt = S_WAIT;
         S_WAIT:   if (nn_done || timeout) state_nxt = S_RESULT;
         S_RESULT: if (res_ready)          state_nxt = S_IDLE;
         default:                          state_nxt = S_IDLE;
      endcase
   end

   // rd_v tracks the buffer read latency so x_valid trails the address by two cycles.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rd_addr   <= '0;
         rd_v      <= 1'b0;
         x         <= '0;
         x_valid   <= 1'b0;
         res_valid <= 1'b0;
         res_class <= '0;
         frame_cnt <= '0;
      end else begin
         rd_v    <= (state == S_STREAM);
         x_valid <= rd_v;
         if (rd_v) x <= rdata;
         case (state)
            S_IDLE:   if (start) rd_addr <= '0;
            S_STREAM: if (!last_addr) rd_addr <= rd_addr + AW'(1);
            S_WAIT: begin
               if (nn_done) begin
                  res_valid <= 1'b1;
                  res_class <= nn_class;
               end else if (timeout) begin
                  res_valid <= 1'b1;
                  res_class <= '1;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed bench for nn_frame_sequencer; the watchdog case follows whether SEQ_TIMEOUT_EN is defined.
module tb_nn_frame_sequencer;

   localparam int N = 784;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [9:0]        wr_addr = '0;
   logic signed [7:0] wr_data = '0;
   logic              start = 1'b0;
   logic              nn_done = 1'b0;
   logic [3:0]        nn_class = '0;
   logic              res_ready = 1'b0;
   logic              busy, x_valid, res_valid, res_err;
   logic signed [7:0] x;
   logic [3:0]        res_class;
   logic [15:0]       frame_cnt;

   logic signed [7:0] exp_pix [N];
   logic signed [7:0] seen    [N];
   int                n_tests = 0;
   int                n_fail  = 0;

   always #5 Clk = ~Clk;

   nn_frame_sequencer #(
      .INPUTsize (N),
      .DW        (8),
      .AW        (10),
      .CLASSW    (4),
      .TIMEOUT   (64)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .x         (x),
      .x_valid   (x_valid),
      .nn_done   (nn_done),
      .nn_class  (nn_class),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_class (res_class),
      .res_err   (res_err),
      .frame_cnt (frame_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic load_image();
      for (int i = 0; i < N; i++) begin
         exp_pix[i] = 8'(i % 128);
         wr_en      = 1'b1;
         wr_addr    = 10'(i);
         wr_data    = 8'(i % 128);
         @(negedge Clk);
      end
      wr_en = 1'b0;
   endtask

   // Pulses start and watches 790 cycles; optional disturbance at cycle 100 or reset at pixel rst_at.
   task automatic run_stream(input bit inject, input int rst_at);
      int nv, first, last, bad;
      nv = 0; first = -1; last = -1; bad = 0;
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int c = 1; c <= 790; c++) begin
         if (inject && c == 100) begin
            wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'h7F; start = 1'b1; nn_done = 1'b1; nn_class = 4'd6;
         end else if (inject && c == 101) begin
            wr_en = 1'b0; start = 1'b0; nn_done = 1'b0;
         end
         @(negedge Clk);
         if (x_valid) begin
            if (first < 0) first = c;
            if (nv < N) begin
               seen[nv] = x;
               if (x !== exp_pix[nv]) bad++;
            end
            nv++;
            last = c;
         end
         if (rst_at >= 0 && nv == rst_at + 1) begin
            chk("pix_before_reset", x, exp_pix[rst_at]);
            #2 Rst = 1'b0;
            #1;
            chk("rst_x_valid", x_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            @(negedge Clk);
            Rst = 1'b1;
            @(negedge Clk);
            return;
         end
      end
      chk("first_pixel_cycle", first, 2);
      chk("stream_len", nv, N);
      chk("last_pixel_cycle", last, 785);
      chk("pixel_errors", bad, 0);
      chk("x_valid_dropped", x_valid, 0);
      chk("x_hold", x, exp_pix[N-1]);
   endtask

   task automatic deliver(input logic [3:0] cls, input logic [15:0] want_cnt);
      nn_done = 1'b1; nn_class = cls;
      @(negedge Clk);
      nn_done = 1'b0; nn_class = 4'd0;
      chk("dlv_res_valid", res_valid, 1);
      chk("dlv_res_class", res_class, cls);
      chk("dlv_res_err", res_err, 0);
      res_ready = 1'b1;
      @(negedge Clk);
      res_ready = 1'b0;
      chk("dlv_hs_valid", res_valid, 0);
      chk("dlv_frame_cnt", frame_cnt, want_cnt);
      chk("dlv_busy", busy, 0);
   endtask

   initial begin
      int bad;
      repeat (2) @(negedge Clk);
      chk("reset_busy", busy, 0);
      chk("reset_x_valid", x_valid, 0);
      chk("reset_x", x, 0);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_class", res_class, 0);
      chk("reset_res_err", res_err, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      Rst = 1'b1;
      @(negedge Clk);

      load_image();
      run_stream(1'b0, -1);
      chk("f1_pix0", seen[0], 0);
      chk("f1_pix783", seen[N-1], 15);
      chk("f1_wait_busy", busy, 1);
      chk("f1_wait_no_result", res_valid, 0);
      repeat (44) @(negedge Clk);
      nn_done = 1'b1; nn_class = 4'd7;
      @(negedge Clk);
      nn_done = 1'b0; nn_class = 4'd3;
      chk("f1_res_valid", res_valid, 1);
      chk("f1_res_class", res_class, 7);
      chk("f1_res_err", res_err, 0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         nn_done  = (i == 3);
         nn_class = 4'd9;
         start    = (i == 5);
         @(negedge Clk);
         if (res_valid !== 1'b1 || res_class !== 4'd7 || busy !== 1'b1) bad++;
      end
      chk("f1_result_hold", bad, 0);
      nn_done = 1'b0; start = 1'b1; res_ready = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      chk("f1_hs_valid", res_valid, 0);
      chk("f1_hs_frame_cnt", frame_cnt, 1);
      chk("f1_hs_busy", busy, 0);
      @(negedge Clk);
      res_ready = 1'b0;
      chk("start_on_hs_ignored", busy, 0);
      chk("ready_without_valid", frame_cnt, 1);

      run_stream(1'b1, -1);
      chk("f2_still_wait", busy, 1);
      chk("f2_nn_done_ignored", res_valid, 0);
      deliver(4'd2, 16'd2);

      wr_en = 1'b1; wr_addr = 10'd800; wr_data = 8'h55;
      @(negedge Clk);
      wr_en = 1'b0;
      run_stream(1'b0, -1);
      chk("f3_pix5_kept", seen[5], 5);
      chk("f3_pix783_kept", seen[N-1], 15);
      deliver(4'd4, 16'd3);

      run_stream(1'b0, 300);
      run_stream(1'b0, -1);
      chk("f5_pix0", seen[0], 0);
`ifdef SEQ_TIMEOUT_EN
      begin
         int c;
         c = 790;
         while (c < 1200 && res_valid !== 1'b1) begin
            @(negedge Clk);
            c++;
         end
         chk("timeout_cycle", c, 848);
         chk("timeout_res_err", res_err, 1);
         chk("timeout_res_class", res_class, 4'hF);
         res_ready = 1'b1;
         @(negedge Clk);
         res_ready = 1'b0;
         chk("timeout_frame_cnt", frame_cnt, 1);
         chk("timeout_idle", busy, 0);
      end
`else
      bad = 0;
      repeat (1000) begin
         @(negedge Clk);
         if (res_valid !== 1'b0) bad++;
      end
      chk("no_watchdog", bad, 0);
      chk("no_watchdog_busy", busy, 1);
      deliver(4'd5, 16'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
